// File: rtl/mem_access_unit.sv
// Purpose: memory stage access unit; turns EX/MEM load/store controls into one req/ack data-memory access with lane steering and load extension.
// Latency: 3 cycles per access with a zero-wait memory (IDLE stall, BUSY, DONE); each memory wait state adds one BUSY cycle.
// Backpressure: Stall_Out holds the upstream pipeline registers until DMem_Ack (or a timeout, when MEM_TIMEOUT_EN is defined) completes the access.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic [1:0]  ByteSel_In,
  input  logic        LoadUnsigned_In,
  input  logic [31:0] Address_In,
  input  logic [31:0] WriteData_In,
  output logic        Stall_Out,
  output logic        DMem_Req,
  output logic        DMem_We,
  output logic [31:0] DMem_Addr,
  output logic [3:0]  DMem_ByteEn,
  output logic [31:0] DMem_WData,
  input  logic        DMem_Ack,
  input  logic [31:0] DMem_RData,
  output logic [31:0] ReadData_Out,
  output logic        ReadValid_Out,
  output logic        Misaligned_Out,
  output logic        Timeout_Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Access shape captured at request time, used to format the returned word.
  logic [1:0] off_q;
  logic       byte_q;
  logic       half_q;
  logic       uns_q;

  logic        valid;
  logic        is_byte;
  logic        is_half;
  logic        aligned;
  logic [3:0]  lanes;
  logic [31:0] wdata_fmt;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_fmt;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] busy_cnt;
`else
  // Without the watchdog the limit has no effect; keep it referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Decode access size, alignment, byte lanes and replicated store data.
  always_comb begin
    valid     = MemRead_In | MemWrite_In;
    is_byte   = (ByteSel_In == 2'b01);
    is_half   = (ByteSel_In == 2'b10);
    aligned   = 1'b0;
    lanes     = 4'b1111;
    wdata_fmt = 32'd0;
    if (is_byte) begin
      aligned   = 1'b1;
      lanes     = 4'b0001 << Address_In[1:0];
      wdata_fmt = {4{WriteData_In[7:0]}};
    end else if (is_half) begin
      aligned   = ~Address_In[0];
      lanes     = Address_In[1] ? 4'b1100 : 4'b0011;
      wdata_fmt = {2{WriteData_In[15:0]}};
    end else begin
      aligned   = (Address_In[1:0] == 2'b00);
      lanes     = 4'b1111;
      wdata_fmt = WriteData_In;
    end
    // Reads never put data on the bus.
    if (!MemWrite_In) wdata_fmt = 32'd0;
  end

  // Select and extend the loaded bytes using the shape captured at request time.
  always_comb begin
    rd_byte = DMem_RData[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? DMem_RData[31:16] : DMem_RData[15:0];
    rd_fmt  = DMem_RData;
    if (byte_q) begin
      rd_fmt = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
    end else if (half_q) begin
      rd_fmt = {{16{rd_half[15] & ~uns_q}}, rd_half};
    end
  end

  // Stall only while an aligned access is being launched or is outstanding.
  assign Stall_Out = Reset & ((state == IDLE) ? (valid & aligned) : (state == BUSY));

  // Access FSM with registered memory-port and result outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      off_q          <= 2'd0;
      byte_q         <= 1'b0;
      half_q         <= 1'b0;
      uns_q          <= 1'b0;
      DMem_Req       <= 1'b0;
      DMem_We        <= 1'b0;
      DMem_Addr      <= 32'd0;
      DMem_ByteEn    <= 4'd0;
      DMem_WData     <= 32'd0;
      ReadData_Out   <= 32'd0;
      ReadValid_Out  <= 1'b0;
      Misaligned_Out <= 1'b0;
      Timeout_Out    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      busy_cnt       <= '0;
`endif
    end else begin
      ReadValid_Out  <= 1'b0;
      Misaligned_Out <= 1'b0;
      Timeout_Out    <= 1'b0;
      case (state)
        IDLE: begin
          if (valid && aligned) begin
            off_q       <= Address_In[1:0];
            byte_q      <= is_byte;
            half_q      <= is_half;
            uns_q       <= LoadUnsigned_In;
            DMem_Req    <= 1'b1;
            DMem_We     <= MemWrite_In;
            DMem_Addr   <= {Address_In[31:2], 2'b00};
            DMem_ByteEn <= lanes;
            DMem_WData  <= wdata_fmt;
            state       <= BUSY;
`ifdef MEM_TIMEOUT_EN
            busy_cnt    <= '0;
`endif
          end else if (valid) begin
            Misaligned_Out <= 1'b1;
          end
        end
        BUSY: begin
          if (DMem_Ack) begin
            DMem_Req <= 1'b0;
            state    <= DONE;
            if (!DMem_We) begin
              ReadData_Out  <= rd_fmt;
              ReadValid_Out <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
          end else if (busy_cnt == CNT_LAST) begin
            // Abort: give writeback a defined zero for a load.
            DMem_Req    <= 1'b0;
            state       <= DONE;
            Timeout_Out <= 1'b1;
            if (!DMem_We) begin
              ReadData_Out  <= 32'd0;
              ReadValid_Out <= 1'b1;
            end
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: self-checking bench for mem_access_unit; loads are scoreboarded on ReadValid_Out.
// Latency: each access is walked cycle by cycle through IDLE, BUSY and DONE.
// Backpressure: the bench models a stalled pipeline by holding inputs until DONE.
module tb_mem_access_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        MemRead_In;
  logic        MemWrite_In;
  logic [1:0]  ByteSel_In;
  logic        LoadUnsigned_In;
  logic [31:0] Address_In;
  logic [31:0] WriteData_In;
  logic        Stall_Out;
  logic        DMem_Req;
  logic        DMem_We;
  logic [31:0] DMem_Addr;
  logic [3:0]  DMem_ByteEn;
  logic [31:0] DMem_WData;
  logic        DMem_Ack;
  logic [31:0] DMem_RData;
  logic [31:0] ReadData_Out;
  logic        ReadValid_Out;
  logic        Misaligned_Out;
  logic        Timeout_Out;

`ifdef MEM_TIMEOUT_EN
  localparam int LONG_WAIT = 3;
`else
  localparam int LONG_WAIT = 4;
`endif

  always #5 Clock = ~Clock;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
    .ByteSel_In(ByteSel_In), .LoadUnsigned_In(LoadUnsigned_In),
    .Address_In(Address_In), .WriteData_In(WriteData_In),
    .Stall_Out(Stall_Out), .DMem_Req(DMem_Req), .DMem_We(DMem_We),
    .DMem_Addr(DMem_Addr), .DMem_ByteEn(DMem_ByteEn), .DMem_WData(DMem_WData),
    .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData),
    .ReadData_Out(ReadData_Out), .ReadValid_Out(ReadValid_Out),
    .Misaligned_Out(Misaligned_Out), .Timeout_Out(Timeout_Out)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  bsel;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          req_rises = 0;
  logic        req_prev = 1'b0;
  logic [31:0] sb [$];
  vec_t        vecs [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every ReadValid pulse must match the oldest expected load result.
  always @(negedge Clock) begin
    if (ReadValid_Out) begin
      if (sb.size() == 0) check("rd_unexpected", {31'd0, ReadValid_Out}, 32'd0);
      else check("rd_data", ReadData_Out, sb.pop_front());
    end
  end

  // Count request launches to catch duplicate requests.
  always @(negedge Clock) begin
    if (DMem_Req && !req_prev) req_rises++;
    req_prev = DMem_Req;
  end

  task automatic idle_inputs();
    MemRead_In = 1'b0; MemWrite_In = 1'b0; ByteSel_In = 2'b00;
    LoadUnsigned_In = 1'b0; Address_In = 32'd0; WriteData_In = 32'd0;
  endtask

  // Drive one access and walk it through IDLE, BUSY (waits+1 cycles) and DONE.
  task automatic run_access(input vec_t v);
    int   rises0;
    logic is_load;
    rises0  = req_rises;
    is_load = v.re & ~v.we;
    MemRead_In = v.re; MemWrite_In = v.we; ByteSel_In = v.bsel;
    LoadUnsigned_In = v.uns; Address_In = v.addr; WriteData_In = v.wdata;
    if (is_load) sb.push_back(v.exp_rd);
    #1 check("stall_idle", {31'd0, Stall_Out}, 32'd1);
    @(negedge Clock);
    for (int i = 0; i <= v.waits; i++) begin
      check("req_busy", {31'd0, DMem_Req}, 32'd1);
      check("stall_busy", {31'd0, Stall_Out}, 32'd1);
      check("we", {31'd0, DMem_We}, {31'd0, v.we});
      check("addr", DMem_Addr, v.exp_addr);
      check("byte_en", {28'd0, DMem_ByteEn}, {28'd0, v.exp_be});
      check("wdata", DMem_WData, v.exp_wd);
      DMem_Ack   = (i == v.waits);
      DMem_RData = (i == v.waits) ? v.rdata : ~v.rdata;
      @(negedge Clock);
    end
    DMem_Ack = 1'b0; DMem_RData = 32'hDEAD_0000;
    check("stall_done", {31'd0, Stall_Out}, 32'd0);
    check("req_done", {31'd0, DMem_Req}, 32'd0);
    check("rvalid_done", {31'd0, ReadValid_Out}, {31'd0, is_load});
    check("timeout_done", {31'd0, Timeout_Out}, 32'd0);
    idle_inputs();
    @(negedge Clock);
    check("rvalid_after", {31'd0, ReadValid_Out}, 32'd0);
    check("req_count", req_rises - rises0, 32'd1);
  endtask

  task automatic run_misaligned(input logic we, input logic re, input logic [1:0] bsel, input logic [31:0] addr);
    int rises0;
    rises0 = req_rises;
    MemRead_In = re; MemWrite_In = we; ByteSel_In = bsel; Address_In = addr; WriteData_In = 32'h1234_5678;
    #1 check("mis_stall", {31'd0, Stall_Out}, 32'd0);
    @(negedge Clock);
    check("mis_pulse", {31'd0, Misaligned_Out}, 32'd1);
    check("mis_req", {31'd0, DMem_Req}, 32'd0);
    idle_inputs();
    @(negedge Clock);
    check("mis_clear", {31'd0, Misaligned_Out}, 32'd0);
    check("mis_req_count", req_rises - rises0, 32'd0);
  endtask

  // Reset while BUSY, then a late Ack that must be ignored.
  task automatic reset_mid_busy(input int busy_cycles);
    MemRead_In = 1'b1; ByteSel_In = 2'b00; Address_In = 32'h0000_B000;
    @(negedge Clock);
    for (int i = 0; i < busy_cycles; i++) begin
      check("hold_stall", {31'd0, Stall_Out}, 32'd1);
      check("hold_req", {31'd0, DMem_Req}, 32'd1);
      check("hold_timeout", {31'd0, Timeout_Out}, 32'd0);
      @(negedge Clock);
    end
    Reset = 1'b0;
    #1;
    check("rst_stall", {31'd0, Stall_Out}, 32'd0);
    check("rst_req", {31'd0, DMem_Req}, 32'd0);
    check("rst_we", {31'd0, DMem_We}, 32'd0);
    check("rst_addr", DMem_Addr, 32'd0);
    check("rst_be", {28'd0, DMem_ByteEn}, 32'd0);
    check("rst_wdata", DMem_WData, 32'd0);
    check("rst_rdata", ReadData_Out, 32'd0);
    check("rst_rvalid", {31'd0, ReadValid_Out}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    idle_inputs();
    @(negedge Clock);
    DMem_Ack = 1'b1; DMem_RData = 32'h5555_AAAA;
    @(negedge Clock);
    DMem_Ack = 1'b0;
    check("late_ack_req", {31'd0, DMem_Req}, 32'd0);
    check("late_ack_rvalid", {31'd0, ReadValid_Out}, 32'd0);
    check("late_ack_rdata", ReadData_Out, 32'd0);
    check("late_ack_stall", {31'd0, Stall_Out}, 32'd0);
    @(negedge Clock);
    check("late_ack_rvalid2", {31'd0, ReadValid_Out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; DMem_Ack = 1'b0; DMem_RData = 32'd0;
    idle_inputs();
    //            we    re    bsel   uns   addr          wdata         rdata         waits      exp_addr      be       exp_wd        exp_rd
    vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1003, 32'h1234_56A5, 32'h0,        0,         32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_2002, 32'h0,        32'h8001_1234, 0,         32'h0000_2000, 4'b1100, 32'h0,        32'hFFFF_8001});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b1, 32'h0000_2002, 32'h0,        32'h8001_1234, 0,         32'h0000_2000, 4'b1100, 32'h0,        32'h0000_8001});
    vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_4000, 32'h0,        32'hDEAD_BEEF, LONG_WAIT, 32'h0000_4000, 4'b1111, 32'h0,        32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_5001, 32'h0,        32'h1122_8033, 1,         32'h0000_5000, 4'b0010, 32'h0,        32'hFFFF_FF80});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_5002, 32'h0,        32'h11FF_8033, 0,         32'h0000_5000, 4'b0100, 32'h0,        32'h0000_00FF});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'hCAFE_1234, 32'h0,        1,         32'h0000_6000, 4'b0011, 32'h1234_1234, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_7004, 32'h89AB_CDEF, 32'h0,        2,         32'h0000_7004, 4'b1111, 32'h89AB_CDEF, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_8000, 32'h0102_0304, 32'h7777_7777, 0,         32'h0000_8000, 4'b1111, 32'h0102_0304, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_2000, 32'h0,        32'hFFFF_7FFF, 0,         32'h0000_2000, 4'b0011, 32'h0,        32'h0000_7FFF});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_9000, 32'h0,        32'h8000_0000, 0,         32'h0000_9000, 4'b1111, 32'h0,        32'h8000_0000});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b1, 32'h0000_3002, 32'h0,        32'hABCD_0000, 0,         32'h0000_3000, 4'b1100, 32'h0,        32'h0000_ABCD});

    @(negedge Clock);
    @(negedge Clock);
    check("reset_stall", {31'd0, Stall_Out}, 32'd0);
    check("reset_req", {31'd0, DMem_Req}, 32'd0);
    check("reset_rdata", ReadData_Out, 32'd0);
    check("reset_rvalid", {31'd0, ReadValid_Out}, 32'd0);
    check("reset_mis", {31'd0, Misaligned_Out}, 32'd0);
    check("reset_timeout", {31'd0, Timeout_Out}, 32'd0);
    Reset = 1'b1;
    @(negedge Clock);

    // Ack while idle must not start anything.
    DMem_Ack = 1'b1; DMem_RData = 32'hFFFF_FFFF;
    @(negedge Clock);
    DMem_Ack = 1'b0;
    check("idle_ack_req", {31'd0, DMem_Req}, 32'd0);
    check("idle_ack_rvalid", {31'd0, ReadValid_Out}, 32'd0);

    for (int i = 0; i < vecs.size() - 1; i++) run_access(vecs[i]);

    run_misaligned(1'b0, 1'b1, 2'b00, 32'h0000_3001);
    run_misaligned(1'b1, 1'b0, 2'b10, 32'h0000_3001);
    run_misaligned(1'b1, 1'b0, 2'b00, 32'h0000_3002);
    run_access(vecs[vecs.size() - 1]);

`ifdef MEM_TIMEOUT_EN
    // Load with no Ack: aborted after four BUSY cycles with a zero result.
    MemRead_In = 1'b1; ByteSel_In = 2'b00; Address_In = 32'h0000_A000;
    sb.push_back(32'd0);
    @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      check("tmo_req", {31'd0, DMem_Req}, 32'd1);
      check("tmo_pending", {31'd0, Timeout_Out}, 32'd0);
      @(negedge Clock);
    end
    check("tmo_pulse", {31'd0, Timeout_Out}, 32'd1);
    check("tmo_req_drop", {31'd0, DMem_Req}, 32'd0);
    check("tmo_rvalid", {31'd0, ReadValid_Out}, 32'd1);
    check("tmo_rdata", ReadData_Out, 32'd0);
    check("tmo_stall", {31'd0, Stall_Out}, 32'd0);
    idle_inputs();
    @(negedge Clock);
    check("tmo_clear", {31'd0, Timeout_Out}, 32'd0);
    run_access(vecs[3]);
    reset_mid_busy(2);
`else
    // Without the watchdog a missing Ack stalls indefinitely; reset recovers.
    reset_mid_busy(20);
`endif

    run_access(vecs[0]);
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer side of the EX/MEM pipeline register. Takes the registered memory-stage controls (MemRead, MemWrite, ByteSel, ALU address, store data) and performs the access on a req/ack data-memory port.
- Generates byte-lane enables and store-data replication, and extracts and sign-extends load data.
- Drives Stall_Out to the pipeline-register WriteEnable logic while an access is outstanding.
- Sits between EX/MEM and MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without DMem_Ack before the access is aborted. Used only with MEM_TIMEOUT_EN.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MemRead_In  in  1  load request from EX/MEM.
- MemWrite_In  in  1  store request from EX/MEM.
- ByteSel_In  in  2  access size: 00 word, 01 byte, 10 halfword, 11 treated as word.
- LoadUnsigned_In  in  1  1 = zero-extend loads, 0 = sign-extend.
- Address_In  in  32  byte address (ALU result).
- WriteData_In  in  32  store data, right-aligned.
- Stall_Out  out  1  1 = hold IF/ID, ID/EX and EX/MEM.
- DMem_Req  out  1  memory request, held until acked.
- DMem_We  out  1  1 = write.
- DMem_Addr  out  32  word address, {Address[31:2],2'b00}.
- DMem_ByteEn  out  4  byte-lane enables, little-endian.
- DMem_WData  out  32  lane-replicated store data.
- DMem_Ack  in  1  access complete; read data valid the same cycle.
- DMem_RData  in  32  read word.
- ReadData_Out  out  32  formatted load result.
- ReadValid_Out  out  1  one-cycle pulse when ReadData_Out is updated by a load.
- Misaligned_Out  out  1  one-cycle pulse on a misaligned access.
- Timeout_Out  out  1  one-cycle pulse on an aborted access.

Behaviour:
- Reset (Reset=0): asynchronous. State goes to IDLE; every output goes to 0, including ReadData_Out. Reset asserted mid-access aborts the access silently, and any later Ack is ignored.
- Alignment check: an access is aligned if it is a byte access, a halfword with Address[0]=0, or a word with Address[1:0]=00. Valid = MemRead_In|MemWrite_In.
- If both MemRead_In and MemWrite_In are high, the write takes priority and DMem_We=1.
- IDLE:
  - Stall_Out = Valid & aligned (combinational).
  - On a valid aligned access: latch address, lanes, data, We and LoadUnsigned; set DMem_Req=1; go to BUSY.
  - On a valid misaligned access: no request and no stall; Misaligned_Out=1 next cycle for one cycle.
- BUSY:
  - Stall_Out=1. DMem_Req/We/Addr/ByteEn/WData stay stable.
  - On DMem_Ack=1: DMem_Req=0 next cycle; go to DONE.
  - For a load, ReadData_Out is captured from DMem_RData on the Ack edge, and ReadValid_Out=1 during DONE.
- DONE:
  - Stall_Out=0, so EX/MEM advances at the end of this cycle.
  - Inputs are ignored; unconditionally return to IDLE.
- Latency: zero-wait memory costs 3 cycles per access (IDLE-stall, BUSY, DONE). Each memory wait state adds one BUSY cycle.
- DMem_Ack in IDLE or DONE is ignored.
- Store lanes:
  - Byte at offset k: ByteEn = 1<<k, WData = {4{WriteData[7:0]}}.
  - Halfword: ByteEn = 0011 when Address[1]=0, 1100 when Address[1]=1; WData = {2{WriteData[15:0]}}.
  - Word: ByteEn = 1111, WData = WriteData.
  - For reads, DMem_WData=0 and DMem_ByteEn shows the lanes being read.
- Load extract:
  - Byte k = RData[8k+7:8k]; halfword = RData[16h+15:16h] with h = Address[1].
  - Extended to 32 bits per the latched LoadUnsigned.
  - ReadData_Out holds its value until the next load completes.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit minimum (ceil-log2) BUSY counter is built in, cleared on entry to BUSY.
  - When it reaches TIMEOUT_CYCLES without Ack: DMem_Req drops, the state goes to DONE, and Timeout_Out pulses 1 during DONE.
  - For a load, ReadData_Out=0 and ReadValid_Out=1 (so WB sees a defined value).
  - Ack in the same cycle as the timeout wins: normal completion, no Timeout_Out.
- MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; Timeout_Out is tied 0.

Test Plan:
- Byte store, zero-wait: MemWrite=1, ByteSel=01, Address=0x1003, WriteData=0xA5 -> DMem_Addr=0x1000, ByteEn=1000, WData=0xA5A5A5A5, Stall high for 2 cycles, low in DONE.
- Signed halfword load: ByteSel=10, Address=0x2002, RData=0x8001_1234, LoadUnsigned=0 -> ReadData_Out=0xFFFF8001 and ReadValid pulse; with LoadUnsigned=1 -> 0x00008001.
- Wait states: word load, Ack after 5 cycles -> Req held high and stable for 5 cycles, Stall high for 6 cycles, one ReadValid pulse, one request only.
- Misaligned: word read at 0x3001 -> no DMem_Req, Stall stays 0, Misaligned_Out pulses once; then halfword at 0x3002 proceeds normally.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): load with Ack never asserted -> Req drops after 4 BUSY cycles, Timeout_Out=1, ReadData_Out=0; without the macro, Stall stays high indefinitely.
- Reset mid-BUSY: drop Reset in BUSY, then deliver Ack after release -> all outputs 0, state IDLE, Ack ignored, no ReadValid.
